// File: rtl/fetch_pc_unit_pkg.sv
// Shared core constants: datapath width, reset/NOP values, fetch FSM encoding, opcodes.
// Imported by the fetch stage and by decode/immediate generation.
package fetch_pc_unit_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/ready plus decode valid/ready.
// master = fetch unit side, slave = memory/decode side.
interface fetch_pc_unit_if #(
  parameter int XLEN = fetch_pc_unit_pkg::XLEN
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            branch_taken;
  logic [XLEN-1:0] imm_ext;
  logic            misaligned;
  logic [31:0]     retire_count;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, misaligned, retire_count,
    input  imem_ready, imem_rdata, instr_ready, branch_taken, imm_ext
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, misaligned, retire_count,
    output imem_ready, imem_rdata, instr_ready, branch_taken, imm_ext
  );
endinterface

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// Next-PC adder: taken branch -> pc+imm, else pc+4 (mod 2^XLEN); flags word misalignment.
// Purely combinational, no handshake.
module fetch_pc_unit_next_pc_calc #(
  parameter int XLEN = fetch_pc_unit_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_instr_pc,
  input  logic [XLEN-1:0] i_imm_ext,
  input  logic            i_branch_taken,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);
  logic [XLEN-1:0] w_offset;

  assign w_offset     = i_branch_taken ? i_imm_ext : XLEN'(4);
  assign o_next_pc    = i_instr_pc + w_offset;
  assign o_misaligned = (o_next_pc[1:0] != 2'b00);
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: one outstanding fetch, instruction held for decode until retired; imem_ready->instr_valid 1 cycle.
// Memory stalls hold imem_addr; decode stalls hold instr; misaligned target halts until reset.
module fetch_pc_unit #(
  parameter int              XLEN      = fetch_pc_unit_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = fetch_pc_unit_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = fetch_pc_unit_pkg::NOP_INSTR
) (
  input  logic             i_clk,
  input  logic             i_reset,
  fetch_pc_unit_if.master  io_bus
);
  import fetch_pc_unit_pkg::*;

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_instr_pc, w_instr_pc_nxt;
  logic [31:0]     r_instr, w_instr_nxt;
  logic            r_instr_valid, w_instr_valid_nxt;
  logic            r_misaligned, w_misaligned_nxt;
  logic [31:0]     r_retire_count, w_retire_count_nxt;
  logic [XLEN-1:0] w_next_pc;
  logic            w_tgt_misaligned;

  fetch_pc_unit_next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
    .i_instr_pc     (r_instr_pc),
    .i_imm_ext      (io_bus.imm_ext),
    .i_branch_taken (io_bus.branch_taken),
    .o_next_pc      (w_next_pc),
    .o_misaligned   (w_tgt_misaligned)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_FETCH;
      r_pc           <= RESET_PC;
      r_instr        <= NOP_INSTR;
      r_instr_pc     <= RESET_PC;
      r_instr_valid  <= 1'b0;
      r_misaligned   <= 1'b0;
      r_retire_count <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_instr        <= w_instr_nxt;
      r_instr_pc     <= w_instr_pc_nxt;
      r_instr_valid  <= w_instr_valid_nxt;
      r_misaligned   <= w_misaligned_nxt;
      r_retire_count <= w_retire_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_instr_nxt        = r_instr;
    w_instr_pc_nxt     = r_instr_pc;
    w_instr_valid_nxt  = r_instr_valid;
    w_misaligned_nxt   = r_misaligned;
    w_retire_count_nxt = r_retire_count;
    case (r_state)
      ST_FETCH: begin
        if (io_bus.imem_ready) begin
          w_instr_nxt       = io_bus.imem_rdata;
          w_instr_pc_nxt    = r_pc;
          w_instr_valid_nxt = 1'b1;
          w_state_nxt       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (io_bus.instr_ready) begin
          w_retire_count_nxt = r_retire_count + 32'd1;
          w_instr_valid_nxt  = 1'b0;
          w_instr_nxt        = NOP_INSTR;
          // A misaligned target is never fetched: pc keeps the last good value.
          if (w_tgt_misaligned) begin
            w_misaligned_nxt = 1'b1;
            w_state_nxt      = ST_HALT;
          end else begin
            w_pc_nxt    = w_next_pc;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  assign io_bus.imem_req     = (r_state == ST_FETCH) && !i_reset;
  assign io_bus.imem_addr    = r_pc;
  assign io_bus.instr        = r_instr;
  assign io_bus.instr_pc     = r_instr_pc;
  assign io_bus.instr_valid  = r_instr_valid;
  assign io_bus.misaligned   = r_misaligned;
  assign io_bus.retire_count = r_retire_count;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: scoreboard of expected fetch addresses and held instructions,
// plus a second instance with RESET_PC near the top of the address space.
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_w = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_unit_if #(.XLEN(32)) bus ();
  fetch_pc_unit_if #(.XLEN(32)) bus_w ();

  fetch_pc_unit dut (.i_clk(clk), .i_reset(rst), .io_bus(bus.master));
  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (.i_clk(clk), .i_reset(rst_w), .io_bus(bus_w.master));

  typedef struct { logic [31:0] word; logic [31:0] pc; } held_t;
  typedef struct { logic [31:0] word; int waits; int stall; logic bt; logic [31:0] imm; } step_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] fetch_q[$];
  held_t       held_q[$];
  logic [31:0] cur_pc, cur_word;
  logic [31:0] exp_retire;
  step_t       steps[11];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Entered at a negedge where the DUT should be requesting; leaves at the negedge it holds the word.
  task automatic fetch_one(input logic [31:0] word, input int waits);
    logic [31:0] a;
    held_t h;
    if (fetch_q.size() == 0) begin
      chk("sb_fetch_empty", 32'd1, 32'd0);
      return;
    end
    a = fetch_q.pop_front();
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", 32'(bus.imem_req), 32'd1);
      chk("wait_addr", bus.imem_addr, a);
      chk("wait_valid", 32'(bus.instr_valid), 32'd0);
      bus.imem_ready = 1'b0;
      @(negedge clk);
    end
    chk("req", 32'(bus.imem_req), 32'd1);
    chk("addr", bus.imem_addr, a);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    held_q.push_back('{word, a});
    @(negedge clk);
    bus.imem_rdata = 32'hDEAD_BEEF;
    h = held_q.pop_front();
    chk("hold_valid", 32'(bus.instr_valid), 32'd1);
    chk("hold_instr", bus.instr, h.word);
    chk("hold_pc", bus.instr_pc, h.pc);
    chk("hold_req", 32'(bus.imem_req), 32'd0);
    cur_pc   = h.pc;
    cur_word = h.word;
  endtask

  task automatic retire(input logic bt, input logic [31:0] imm, input int stall);
    logic [31:0] nxt;
    for (int i = 0; i < stall; i++) begin
      bus.instr_ready = 1'b0;
      bus.imem_ready  = 1'b1;
      @(negedge clk);
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_instr", bus.instr, cur_word);
      chk("stall_pc", bus.instr_pc, cur_pc);
      chk("stall_req", 32'(bus.imem_req), 32'd0);
      chk("stall_retire", bus.retire_count, exp_retire);
    end
    bus.instr_ready  = 1'b1;
    bus.branch_taken = bt;
    bus.imm_ext      = imm;
    nxt = cur_pc + (bt ? imm : 32'd4);
    exp_retire = exp_retire + 32'd1;
    if (nxt[1:0] == 2'b00) fetch_q.push_back(nxt);
    @(negedge clk);
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.imm_ext      = 32'd0;
    chk("ret_count", bus.retire_count, exp_retire);
    chk("ret_valid", 32'(bus.instr_valid), 32'd0);
    chk("ret_instr", bus.instr, NOP_INSTR);
    chk("ret_misal", 32'(bus.misaligned), 32'(nxt[1:0] != 2'b00));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    steps = '{
      '{32'h0050_0093, 0, 0, 1'b0, 32'h0},
      '{32'h0050_0093, 0, 0, 1'b0, 32'h0},
      '{32'h0050_0093, 3, 0, 1'b0, 32'h0},
      '{32'h0010_8113, 0, 0, 1'b0, 32'h0},
      '{32'hFE00_0CE3, 0, 0, 1'b1, 32'hFFFF_FFF8},
      '{32'h0000_0463, 0, 0, 1'b1, 32'h8},
      '{32'h0200_0063, 0, 0, 1'b1, 32'h20},
      '{32'hFE00_00E3, 0, 0, 1'b1, 32'hFFFF_FFE0},
      '{32'h00A0_0193, 0, 4, 1'b0, 32'h0},
      '{32'h0000_0663, 0, 0, 1'b1, 32'hC},
      '{32'h0000_0363, 1, 0, 1'b1, 32'h6}
    };
    bus.imem_ready     = 1'b1;
    bus.imem_rdata     = 32'h1234_5678;
    bus.instr_ready    = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.imm_ext        = 32'd0;
    bus_w.imem_ready   = 1'b0;
    bus_w.imem_rdata   = 32'd0;
    bus_w.instr_ready  = 1'b0;
    bus_w.branch_taken = 1'b0;
    bus_w.imm_ext      = 32'd0;
    exp_retire = 32'd0;
    cur_pc     = 32'd0;
    cur_word   = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state, with imem_ready asserted throughout reset.
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, NOP_INSTR);
    chk("rst_ipc", bus.instr_pc, 32'd0);
    chk("rst_misal", 32'(bus.misaligned), 32'd0);
    chk("rst_retire", bus.retire_count, 32'd0);
    rst = 1'b0;
    bus.imem_ready = 1'b0;
    fetch_q.push_back(32'd0);
    @(negedge clk);

    foreach (steps[i]) begin
      fetch_one(steps[i].word, steps[i].waits);
      retire(steps[i].bt, steps[i].imm, steps[i].stall);
    end

    // Halted after the misaligned target: everything ignored.
    for (int i = 0; i < 5; i++) begin
      bus.imem_ready   = 1'b1;
      bus.instr_ready  = 1'b1;
      bus.branch_taken = 1'b1;
      bus.imm_ext      = 32'd4;
      @(negedge clk);
      chk("halt_req", 32'(bus.imem_req), 32'd0);
      chk("halt_valid", 32'(bus.instr_valid), 32'd0);
      chk("halt_misal", 32'(bus.misaligned), 32'd1);
      chk("halt_retire", bus.retire_count, exp_retire);
    end
    bus.instr_ready = 1'b0;
    bus.imem_ready  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rerst_misal", 32'(bus.misaligned), 32'd0);
    chk("rerst_req", 32'(bus.imem_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rerst_req_up", 32'(bus.imem_req), 32'd1);
    chk("rerst_addr", bus.imem_addr, 32'd0);
    chk("rerst_retire", bus.retire_count, 32'd0);
    chk("sb_leftover", 32'(fetch_q.size()), 32'd0);

    // PC wrap from the top of the address space, then reset mid-fetch.
    rst_w = 1'b0;
    @(negedge clk);
    chk("w_req", 32'(bus_w.imem_req), 32'd1);
    chk("w_addr", bus_w.imem_addr, 32'hFFFF_FFFC);
    bus_w.imem_ready = 1'b1;
    bus_w.imem_rdata = 32'h0050_0093;
    @(negedge clk);
    bus_w.imem_ready = 1'b0;
    chk("w_valid", 32'(bus_w.instr_valid), 32'd1);
    chk("w_ipc", bus_w.instr_pc, 32'hFFFF_FFFC);
    bus_w.instr_ready = 1'b1;
    @(negedge clk);
    bus_w.instr_ready = 1'b0;
    chk("w_wrap_req", 32'(bus_w.imem_req), 32'd1);
    chk("w_wrap_addr", bus_w.imem_addr, 32'd0);
    chk("w_wrap_retire", bus_w.retire_count, 32'd1);
    bus_w.imem_ready = 1'b1;
    rst_w = 1'b1;
    @(negedge clk);
    chk("w_rst_valid", 32'(bus_w.instr_valid), 32'd0);
    chk("w_rst_req", 32'(bus_w.imem_req), 32'd0);
    rst_w = 1'b0;
    bus_w.imem_ready = 1'b0;
    @(negedge clk);
    chk("w_post_addr", bus_w.imem_addr, 32'hFFFF_FFFC);
    chk("w_post_req", 32'(bus_w.imem_req), 32'd1);
    chk("w_post_valid", 32'(bus_w.instr_valid), 32'd0);
    chk("w_post_retire", bus_w.retire_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
